// File: rtl/audio_sd_dac.sv
// Volume-scaled first-order sigma-delta (PDM) output stage with a Wishbone
// control/status window; reports sample-stream overrun and starvation.
module audio_sd_dac #(
  parameter int          AUDIO_BDEPTH   = 8,
  parameter int unsigned BASE_ADDRESS   = 16'h0000,
  parameter int          ADDRESS_WIDTH  = 16,
  parameter int          DATA_WIDTH     = 8,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic                     we_i,
  input  logic                     sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  output logic                     ack_o,
  input  logic [2:0]               cti_i,
  input  logic [AUDIO_BDEPTH-1:0]  audio_in,
  input  logic                     valid_in,
  output logic                     pdm_o,
  output logic                     amp_en_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = AUDIO_BDEPTH + 9;
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AUDIO_BDEPTH-1:0] MID = {1'b1, {(AUDIO_BDEPTH-1){1'b0}}};

  logic [ADDRESS_WIDTH-1:0] off;
  logic                     in_win, req, take, wr, wr_ctrl, wr_vol, clr;
  logic [DATA_WIDTH-1:0]    rd_dat;

  logic                     enable, mute;
  logic [7:0]               volume, count;
  logic                     overrun, underrun, starved, running, und_set;
  logic [TW-1:0]            timer;

  logic [AUDIO_BDEPTH-1:0]  sample, scaled, u, acc;
  logic                     vld_d;
  logic signed [PW-1:0]     prod;
  logic [AUDIO_BDEPTH:0]    sum;
  logic                     unused_ok;

  // Unsigned offset compare keeps the window test independent of BASE_ADDRESS.
  assign off     = adr_i - ADDRESS_WIDTH'(BASE_ADDRESS);
  assign in_win  = (off < ADDRESS_WIDTH'(4));
  assign req     = cyc_i & stb_i & in_win;
  assign take    = req & ~ack_o;
  assign wr      = take & we_i;
  assign wr_ctrl = wr & (off[1:0] == 2'd0);
  assign wr_vol  = wr & (off[1:0] == 2'd1);
  assign clr     = wr_ctrl & dat_i[2];

  always_comb begin
    rd_dat = '0;
    case (off[1:0])
      2'd0:    rd_dat[1:0] = {mute, enable};
      2'd1:    rd_dat[7:0] = volume;
      2'd2:    rd_dat[2:0] = {starved, underrun, overrun};
      default: rd_dat[7:0] = count;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      dat_o  <= '0;
      enable <= 1'b0;
      mute   <= 1'b0;
      volume <= 8'hFF;
    end else begin
      ack_o <= take;
      if (take)    dat_o <= rd_dat;
      if (wr_ctrl) {mute, enable} <= dat_i[1:0];
      if (wr_vol)  volume <= dat_i[7:0];
    end
  end

  // Zero-extended volume makes the multiply signed x unsigned; the slice is a floor shift.
  assign prod = $signed(sample) * $signed({1'b0, volume});
  assign sum  = {1'b0, acc} + {1'b0, u};
  assign und_set = running & ~valid_in & (timer == T_PRE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_d  <= 1'b0;
      sample <= '0;
      count  <= '0;
      scaled <= '0;
      u      <= '0;
    end else begin
      vld_d <= valid_in;
      if (valid_in) begin
        sample <= audio_in;
        count  <= count + 8'd1;
      end
      if (vld_d) scaled <= prod[AUDIO_BDEPTH+7:8];
      u <= (mute | starved) ? MID : {~scaled[AUDIO_BDEPTH-1], scaled[AUDIO_BDEPTH-2:0]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
      starved  <= 1'b0;
      running  <= 1'b0;
      timer    <= '0;
    end else begin
      overrun  <= (valid_in & vld_d) | (overrun & ~clr);
      underrun <= und_set | (underrun & ~clr);
      if (valid_in) begin
        timer   <= '0;
        running <= 1'b1;
        starved <= 1'b0;
      end else if (running && timer != T_MAX) begin
        timer <= timer + TW'(1);
        if (timer == T_PRE) starved <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc      <= '0;
      pdm_o    <= 1'b0;
      amp_en_o <= 1'b0;
    end else begin
      amp_en_o <= enable & ~starved;
      if (!enable) begin
        acc   <= '0;
        pdm_o <= 1'b0;
      end else begin
        acc   <= sum[AUDIO_BDEPTH-1:0];
        pdm_o <= sum[AUDIO_BDEPTH];
      end
    end
  end

  assign unused_ok = ^{sel_i, cti_i, prod[7:0], prod[PW-1]};

endmodule

// File: tb/tb_audio_sd_dac.sv
// Directed bench for audio_sd_dac: register access, PDM densities, mute/enable,
// overrun, starvation and asynchronous reset.
module tb_audio_sd_dac;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] adr_i;
  logic [7:0]  dat_i;
  logic [7:0]  dat_o;
  logic        we_i, sel_i, stb_i, cyc_i, ack_o;
  logic [2:0]  cti_i;
  logic [7:0]  audio_in;
  logic        valid_in;
  logic        pdm_o, amp_en_o;

  int n_vec = 0;
  int n_err = 0;

  audio_sd_dac dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .cti_i(cti_i), .audio_in(audio_in), .valid_in(valid_in),
    .pdm_o(pdm_o), .amp_en_o(amp_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    check("ack idle before write", ack_o, 1'b0);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    tick(1);
    check("ack on write", ack_o, 1'b1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick(1);
    check("ack single pulse after write", ack_o, 1'b0);
  endtask

  task automatic bus_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    check("ack idle before read", ack_o, 1'b0);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a;
    tick(1);
    check("ack on read", ack_o, 1'b1);
    check(tag, dat_o, exp);
    cyc_i = 1'b0; stb_i = 1'b0;
    tick(1);
    check("ack single pulse after read", ack_o, 1'b0);
  endtask

  task automatic send(input logic [7:0] s);
    audio_in = s; valid_in = 1'b1;
    tick(1);
    valid_in = 1'b0;
  endtask

  // Counts ones on pdm_o over 256 consecutive edges starting 3 edges after the call point.
  task automatic density(input string tag, input int exp);
    int ones;
    ones = 0;
    tick(2);
    for (int i = 0; i < 256; i++) begin
      tick(1);
      ones += int'(pdm_o);
    end
    check(tag, ones, exp);
  endtask

  initial begin
    rst_i = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; sel_i = 1'b1;
    stb_i = 1'b0; cyc_i = 1'b0; cti_i = 3'b000; audio_in = '0; valid_in = 1'b0;
    tick(3);
    check("reset pdm_o", pdm_o, 1'b0);
    check("reset amp_en_o", amp_en_o, 1'b0);
    check("reset ack_o", ack_o, 1'b0);
    check("reset dat_o", dat_o, 8'h00);
    rst_i = 1'b0;
    tick(1);

    bus_rd("reset VOLUME", 16'd1, 8'hFF);
    bus_rd("reset CTRL", 16'd0, 8'h00);
    bus_rd("reset STATUS", 16'd2, 8'h00);
    bus_rd("reset COUNT", 16'd3, 8'h00);

    // Held request acks every other cycle.
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 16'd1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("held request ack pattern", ack_o, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    adr_i = 16'd4;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("out-of-window no ack", ack_o, 1'b0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    tick(1);

    // 64 * 128/256 = 32 -> U = 160
    bus_wr(16'd1, 8'h80);
    bus_wr(16'd0, 8'h01);
    send(8'd64);
    density("density +64 vol 80", 160);
    check("amp_en enabled", amp_en_o, 1'b1);

    bus_wr(16'd1, 8'hFF);
    send(8'h80);
    density("density -128", 0);
    send(8'hFF);
    density("density -1", 127);
    send(8'h01);
    density("density +1", 128);

    send(8'h80);
    bus_wr(16'd0, 8'h03);
    density("density muted", 128);
    bus_rd("CTRL readback mute", 16'd0, 8'h03);

    bus_wr(16'd0, 8'h00);
    tick(1);
    check("disable pdm_o", pdm_o, 1'b0);
    check("disable amp_en_o", amp_en_o, 1'b0);
    density("density disabled", 0);

    bus_wr(16'd3, 8'h55);
    bus_rd("COUNT ignores write", 16'd3, 8'd5);
    bus_wr(16'd2, 8'hFF);
    bus_rd("STATUS ignores write", 16'd2, 8'h00);

    audio_in = 8'd10; valid_in = 1'b1;
    tick(1);
    audio_in = 8'd20;
    tick(1);
    valid_in = 1'b0;
    tick(1);
    bus_rd("STATUS overrun", 16'd2, 8'h01);
    bus_rd("COUNT after overrun", 16'd3, 8'd7);
    bus_wr(16'd0, 8'h05);
    bus_rd("STATUS after CLR", 16'd2, 8'h00);
    bus_rd("CTRL CLR reads 0", 16'd0, 8'h01);

    tick(4200);
    bus_rd("STATUS starved", 16'd2, 8'h06);
    check("amp_en starved", amp_en_o, 1'b0);
    density("density starved", 128);

    send(8'd0);
    check("amp_en edge of resume", amp_en_o, 1'b0);
    tick(1);
    check("amp_en after resume", amp_en_o, 1'b1);
    bus_rd("STATUS after resume", 16'd2, 8'h02);
    bus_rd("COUNT final", 16'd3, 8'd8);

    // Asynchronous assertion must clear outputs without a clock edge.
    rst_i = 1'b1;
    #1;
    check("async reset amp_en_o", amp_en_o, 1'b0);
    check("async reset dat_o", dat_o, 8'h00);
    check("async reset pdm_o", pdm_o, 1'b0);
    tick(2);
    rst_i = 1'b0;
    tick(1);
    bus_rd("VOLUME after reset", 16'd1, 8'hFF);
    bus_rd("STATUS after reset", 16'd2, 8'h00);
    bus_rd("COUNT after reset", 16'd3, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_sd_dac.md
Name: audio_sd_dac

Overview:
- Output stage directly downstream of filter_bank; consumes its audio_out/valid_out sample stream.
- Applies a bus-programmable volume and converts each signed sample to a 1-bit first-order sigma-delta (PDM) stream for the badge speaker/RC filter pin.
- Exposes control and status registers on the same 8-bit Wishbone slave bus as filter_bank.
- Reports sample-stream overrun and underrun.

Parameters:
- AUDIO_BDEPTH, 8: sample width; signed two's complement.
- BASE_ADDRESS, 16'h0000: first register address.
- ADDRESS_WIDTH, 16: Wishbone address width.
- DATA_WIDTH, 8: Wishbone data width.
- TIMEOUT_CYCLES, 4096: maximum clocks between valid_in pulses before underrun.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- adr_i  in  ADDRESS_WIDTH  Wishbone address.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data.
- we_i  in  1  write enable.
- sel_i  in  1  byte select; ignored, treated as 1.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- ack_o  out  1  acknowledge.
- cti_i  in  3  cycle type; ignored, classic cycles only.
- audio_in  in  AUDIO_BDEPTH  signed sample, from filter_bank audio_out.
- valid_in  in  1  one-clock sample strobe.
- pdm_o  out  1  sigma-delta bitstream.
- amp_en_o  out  1  speaker amplifier enable.

Behaviour:
- Reset (async assert, sync release): all outputs 0, all internal registers 0 except VOLUME=8'hFF. On assertion mid-operation every state reverts immediately.
- Register map (offset from BASE_ADDRESS):
  - 0 CTRL, RW: bit0 ENABLE, bit1 MUTE, bit2 CLR. CLR is write-1, self-clearing, and always reads 0. Bits 7:3 read 0.
  - 1 VOLUME, RW: gain = VOLUME/256.
  - 2 STATUS, RO: bit0 OVERRUN (sticky), bit1 UNDERRUN (sticky), bit2 STARVED (live, not sticky).
  - 3 COUNT, RO: 8-bit wrapping count of accepted samples.
- Bus handshake:
  - A request is cyc_i&stb_i with adr_i in BASE..BASE+3. ack_o pulses high exactly one clock, on the clock after the request is sampled, and is never asserted two consecutive clocks.
  - A master holding the request sees ack every other cycle.
  - Writes take effect at the edge that raises ack_o; writes to RO registers are dropped.
  - dat_o is registered and valid while ack_o=1; otherwise it holds its last value.
  - Addresses outside the window never ack.
- Sample path:
  - The valid_in edge latches audio_in into SAMPLE and increments COUNT.
  - The next edge computes SCALED = (SAMPLE * {0,VOLUME}) >>> 8, arithmetic with floor, result width AUDIO_BDEPTH. VOLUME is read in that cycle.
  - Modulator input U = SCALED with MSB inverted (offset binary), except:
    - MUTE=1 or STARVED=1: U = 2^(AUDIO_BDEPTH-1), i.e. midscale, 50% density.
    - ENABLE=0: modulator held.
- Modulator:
  - Accumulator ACC is AUDIO_BDEPTH bits. Each clock while ENABLE: {carry,ACC} <= ACC + U, and pdm_o <= carry.
  - Over any 2^AUDIO_BDEPTH consecutive clocks at constant U, the number of 1s on pdm_o equals U exactly.
  - Latency: valid_in at edge t affects U from edge t+2; the first pdm_o bit using the new U appears at edge t+3.
- ENABLE=0: ACC, pdm_o and amp_en_o are forced 0 synchronously. SAMPLE, COUNT and flags still update.
- Overrun: valid_in on the clock immediately after a valid_in sets OVERRUN. The newer sample overwrites the older one; COUNT increments for both.
- Underrun/starvation:
  - A counter clears on valid_in and otherwise saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, STARVED=1 and UNDERRUN is set. STARVED clears on the next valid_in.
  - The counter is not running before the first sample after reset, so STARVED is 0 initially.
- CLR clears OVERRUN and UNDERRUN on the write edge. If a set event occurs on the same edge, the set wins.
- amp_en_o = ENABLE & ~STARVED, registered, one clock behind.

Test Plan:
- Reset with the bus idle, then read VOLUME and CTRL -> 8'hFF and 8'h00; ack_o high exactly one clock per read, 1 cycle after the request.
- CTRL=1, VOLUME=8'h80, a single valid_in with audio_in=+64 -> U=160; exactly 160 ones on pdm_o over the 256 clocks starting t+3.
- VOLUME=8'hFF, samples -128, -1, +1 -> SCALED -128, -1, 0; U 0, 127, 128; measured densities 0/256, 127/256, 128/256.
- CTRL=3 (MUTE) with any input -> 128 ones per 256 clocks. CTRL=0 -> pdm_o=0 and amp_en_o=0 within 2 clocks.
- Two valid_in on consecutive clocks -> STATUS bit0=1, COUNT +2. Write CTRL=5 -> STATUS bit0 reads 0.
- Stop valid_in for TIMEOUT_CYCLES with ENABLE=1 -> STATUS=8'h06, amp_en_o=0, density 50%. The next valid_in gives STATUS=8'h02, and amp_en_o returns to 1 after 2 clocks.
